lmc1992_mw_rx: RTL and testbench
================================

Name: lmc1992_mw_rx

Overview:
Receiving end of the STE microwire link: models the LMC1992 volume/tone controller addressed by the shifter's microwire master. It deserialises the masked bit stream into 11-bit frames, decodes the LMC1992 commands into a register set, and applies master and left/right attenuation to the 8-bit offset-binary DMA audio samples. The block sits between the shifter's audio/microwire outputs and the board audio mixer.

Parameters:
DEV_ADDR, 2'b10, device address that must match frame bits [10:9]
RST_MASTER, 40, reset master volume code (0..40, 40 = 0 dB, -2 dB per step below)
RST_LR, 20, reset left/right volume code (0..20, 20 = 0 dB, -2 dB per step below)

Ports:
clk32  in  1  system clock (32 MHz)
resb  in  1  reset; asynchronous assert, active-low
mw_bclk  in  1  one-cycle bit-slot pulse from the microwire master, 1 per microsecond
mw_en  in  1  mask bit; the slot carries a valid data bit when high
mw_data  in  1  serial data, MSB first
mw_done  in  1  one-cycle end-of-transfer pulse
audio_in_strobe  in  1  new sample pair valid
audio_in_l / audio_in_r  in  8  offset-binary samples (0x80 = silence)
audio_out_strobe  out  1  scaled sample pair valid
audio_out_l / audio_out_r  out  8  scaled offset-binary samples
master_vol  out  6  current master code
left_vol / right_vol  out  5  current channel codes
bass / treble  out  4  tone codes (0..12, 6 = flat)
mix  out  2  input mix select
frame_err  out  1  one-cycle pulse on a malformed frame

Behaviour:
- Reset (resb low, asynchronous): shift reg 0, bit count 0, master_vol=RST_MASTER, left/right=RST_LR, bass=treble=6, mix=1, audio_out_l/r=0x80, audio_out_strobe=0, frame_err=0, pipeline valid bits 0.
- Receiver FSM: IDLE -> SHIFT on the first mw_bclk&&mw_en. In SHIFT, every mw_bclk&&mw_en does shift={shift[9:0],mw_data} and increments the count, which saturates at 15. mw_bclk with mw_en low: no shift.
- mw_done in any state ends the frame and returns to IDLE. The count and shift register clear on the next cycle.
- Simultaneous mw_bclk&&mw_en and mw_done: the bit is shifted in first, and the frame is evaluated including that bit.
- Frame evaluation:
  - count != 11: frame discarded, frame_err pulses for one cycle.
  - count == 11 and bits[10:9] != DEV_ADDR: discarded silently.
  - Otherwise command = bits[8:6], data = bits[5:0].
- Commands:
  - 011 master = min(data, 40)
  - 101 left = min(data[4:0], 20)
  - 100 right = min(data[4:0], 20)
  - 010 treble = min(data[3:0], 12)
  - 001 bass = min(data[3:0], 12)
  - 000 mix = data[1:0]
  - 110, 111 ignored
- Register update is visible on the outputs the cycle after mw_done.
- Audio pipeline (2 stages, no stall). audio_in_strobe at cycle N gives audio_out_strobe at N+2. Outputs hold between strobes.
  - Stage 1: s = {~in[7], in[6:0]} as signed 8-bit. atten = (40-master)+(20-lr), range 0..60, in 2 dB steps. k = atten/3 (table, 0..20), r = atten%3.
  - Stage 2: p = s * M[r] with M = {256, 203, 161}, 17-bit signed. y = p >>> (8+k) (arithmetic, sign-fill for large shifts). out = {~y[7], y[6:0]}.
  - Gains are sampled in stage 1, so a register change mid-pipeline affects only later samples.
- Reset mid-frame discards the partial frame. Reset mid-pipeline drops in-flight samples.

Optional Feature:
LMC_TONE_EN: when defined, bass/treble commands update the registers as specified. When undefined, commands 001/010 are decoded but ignored, bass/treble are tied to 6, and no tone storage is synthesised. Volume and mix behaviour is identical in both builds.

Test Plan:
- Send frame 10_011_100101 (master 37) -> master_vol=37 the cycle after mw_done. Then in 0xFF -> out 0xBF, in 0x00 -> out 0x40, both 2 cycles after the strobe.
- Send 10_101_010100 (left 20) after master 39 (atten 1) -> left in 0xFF gives 0xE4.
- Send frame 10_011_111111 -> master clamps to 40. Send 10_101_111111 -> left clamps to 20.
- Send a 9-bit frame, then a 12-bit frame -> frame_err pulses once per frame, registers unchanged. Send an 11-bit frame with address 01 -> no update and no frame_err.
- Set master 0 and left 0 (atten 60) -> in 0xFF gives 0x80, in 0x00 gives 0x7F.
- Assert the last valid bit in the same cycle as mw_done -> frame accepted. Assert resb low mid-frame -> all outputs return to reset values, and the next full frame decodes correctly.

Source files
------------

// File: rtl/lmc1992_mw_rx.sv
// LMC1992 microwire receiver: deserialises 11-bit frames into volume/tone/mix registers
// and attenuates the DMA sample pair. Define LMC_TONE_EN to keep bass/treble storage.
module lmc1992_mw_rx #(
  parameter logic [1:0]  DEV_ADDR   = 2'b10,
  parameter int unsigned RST_MASTER = 40,
  parameter int unsigned RST_LR     = 20
) (
  input  logic       clk32,
  input  logic       resb,
  input  logic       mw_bclk,
  input  logic       mw_en,
  input  logic       mw_data,
  input  logic       mw_done,
  input  logic       audio_in_strobe,
  input  logic [7:0] audio_in_l,
  input  logic [7:0] audio_in_r,
  output logic       audio_out_strobe,
  output logic [7:0] audio_out_l,
  output logic [7:0] audio_out_r,
  output logic [5:0] master_vol,
  output logic [4:0] left_vol,
  output logic [4:0] right_vol,
  output logic [3:0] bass,
  output logic [3:0] treble,
  output logic [1:0] mix,
  output logic       frame_err
);

  // state  | meaning
  // IDLE   | no bits received since the last mw_done or reset
  // SHIFT  | frame in progress, bits being collected
  typedef enum logic {ST_IDLE, ST_SHIFT} rx_state_e;

  localparam logic [5:0] RST_M6  = 6'(RST_MASTER);
  localparam logic [4:0] RST_LR5 = 5'(RST_LR);

  rx_state_e   state_q;
  logic [10:0] shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        bit_in;
  logic        frame_hit;
  logic [2:0]  cmd;
  logic [5:0]  dat;

  logic [5:0]  master_q;
  logic [4:0]  left_q, right_q;
  logic [1:0]  mix_q;
  logic        frame_err_q;

  logic        v1_q;
  logic [7:0]  s_l_q, s_r_q;
  logic [4:0]  k_l_q, k_r_q;
  logic [1:0]  r_l_q, r_r_q;
  logic        out_stb_q;
  logic [7:0]  out_l_q, out_r_q;

  function automatic logic [5:0] clamp_m(input logic [5:0] v);
    return (v > 6'd40) ? 6'd40 : v;
  endfunction

  function automatic logic [4:0] clamp_lr(input logic [4:0] v);
    return (v > 5'd20) ? 5'd20 : v;
  endfunction

  // {k, r}: attenuation in 2 dB steps split into 6 dB shifts and a 0/2/4 dB residue
  function automatic logic [6:0] atten_kr(input logic [5:0] m, input logic [4:0] lr);
    logic [6:0] a;
    a = (7'd40 - {1'b0, m}) + (7'd20 - {2'b0, lr});
    return {5'(a / 7'd3), 2'(a % 7'd3)};
  endfunction

  function automatic logic [7:0] scale(input logic [7:0] s, input logic [4:0] k,
                                       input logic [1:0] r);
    logic [8:0]         m;
    logic signed [16:0] p;
    logic [5:0]         sh;
    case (r)
      2'd0:    m = 9'd256;
      2'd1:    m = 9'd203;
      default: m = 9'd161;
    endcase
    p  = $signed({{9{s[7]}}, s}) * $signed({8'd0, m});
    sh = 6'd8 + {1'b0, k};
    return 8'(p >>> sh) ^ 8'h80;
  endfunction

  // The bit arriving with mw_done is folded in before the frame is judged
  always_comb begin
    bit_in  = mw_bclk & mw_en;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (bit_in) begin
      if (state_q == ST_IDLE) begin
        shift_d = {10'd0, mw_data};
        cnt_d   = 4'd1;
      end else begin
        shift_d = {shift_q[9:0], mw_data};
        cnt_d   = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
      end
    end
    frame_hit = (cnt_d == 4'd11) && (shift_d[10:9] == DEV_ADDR);
    cmd       = shift_d[8:6];
    dat       = shift_d[5:0];
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      master_q    <= RST_M6;
      left_q      <= RST_LR5;
      right_q     <= RST_LR5;
      mix_q       <= 2'd1;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (mw_done) begin
        state_q <= ST_IDLE;
        shift_q <= '0;
        cnt_q   <= '0;
        if (cnt_d != 4'd11) begin
          frame_err_q <= 1'b1;
        end else if (frame_hit) begin
          case (cmd)
            3'b011:  master_q <= clamp_m(dat);
            3'b101:  left_q   <= clamp_lr(dat[4:0]);
            3'b100:  right_q  <= clamp_lr(dat[4:0]);
            3'b000:  mix_q    <= dat[1:0];
            default: ;
          endcase
        end
      end else if (bit_in) begin
        state_q <= ST_SHIFT;
        shift_q <= shift_d;
        cnt_q   <= cnt_d;
      end
    end
  end

`ifdef LMC_TONE_EN
  logic [3:0] bass_q, treble_q;

  function automatic logic [3:0] clamp_tone(input logic [3:0] v);
    return (v > 4'd12) ? 4'd12 : v;
  endfunction

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      bass_q   <= 4'd6;
      treble_q <= 4'd6;
    end else if (mw_done && frame_hit) begin
      if (cmd == 3'b001) bass_q   <= clamp_tone(dat[3:0]);
      if (cmd == 3'b010) treble_q <= clamp_tone(dat[3:0]);
    end
  end

  assign bass   = bass_q;
  assign treble = treble_q;
`else
  assign bass   = 4'd6;
  assign treble = 4'd6;
`endif

  // Gains are captured with the sample so later register writes never hit it in flight
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      v1_q      <= 1'b0;
      s_l_q     <= '0;
      s_r_q     <= '0;
      k_l_q     <= '0;
      k_r_q     <= '0;
      r_l_q     <= '0;
      r_r_q     <= '0;
      out_stb_q <= 1'b0;
      out_l_q   <= 8'h80;
      out_r_q   <= 8'h80;
    end else begin
      v1_q      <= audio_in_strobe;
      out_stb_q <= v1_q;
      if (audio_in_strobe) begin
        s_l_q            <= {~audio_in_l[7], audio_in_l[6:0]};
        s_r_q            <= {~audio_in_r[7], audio_in_r[6:0]};
        {k_l_q, r_l_q}   <= atten_kr(master_q, left_q);
        {k_r_q, r_r_q}   <= atten_kr(master_q, right_q);
      end
      if (v1_q) begin
        out_l_q <= scale(s_l_q, k_l_q, r_l_q);
        out_r_q <= scale(s_r_q, k_r_q, r_r_q);
      end
    end
  end

  assign master_vol       = master_q;
  assign left_vol         = left_q;
  assign right_vol        = right_q;
  assign mix              = mix_q;
  assign frame_err        = frame_err_q;
  assign audio_out_strobe = out_stb_q;
  assign audio_out_l      = out_l_q;
  assign audio_out_r      = out_r_q;

endmodule

// File: tb/tb_lmc1992_mw_rx.sv
// Self-checking bench for lmc1992_mw_rx: frame decode, error handling and audio scaling
// against a bench-side register model and arithmetic sample model.
module tb_lmc1992_mw_rx;
  logic       clk32 = 1'b0;
  logic       resb;
  logic       mw_bclk, mw_en, mw_data, mw_done;
  logic       audio_in_strobe;
  logic [7:0] audio_in_l, audio_in_r;
  logic       audio_out_strobe;
  logic [7:0] audio_out_l, audio_out_r;
  logic [5:0] master_vol;
  logic [4:0] left_vol, right_vol;
  logic [3:0] bass, treble;
  logic [1:0] mix;
  logic       frame_err;

  lmc1992_mw_rx dut (
    .clk32(clk32), .resb(resb),
    .mw_bclk(mw_bclk), .mw_en(mw_en), .mw_data(mw_data), .mw_done(mw_done),
    .audio_in_strobe(audio_in_strobe), .audio_in_l(audio_in_l), .audio_in_r(audio_in_r),
    .audio_out_strobe(audio_out_strobe), .audio_out_l(audio_out_l), .audio_out_r(audio_out_r),
    .master_vol(master_vol), .left_vol(left_vol), .right_vol(right_vol),
    .bass(bass), .treble(treble), .mix(mix), .frame_err(frame_err)
  );

  always #5 clk32 = ~clk32;

  int n_checks = 0;
  int n_fail   = 0;
  int m_master, m_left, m_right, m_bass, m_treble, m_mix;

  typedef struct { int due; logic [7:0] l; logic [7:0] r; } exp_t;
  exp_t       sb[$];
  logic [7:0] stim_l[$], stim_r[$], want_l[$], want_r[$];

  function automatic logic [7:0] model_sample(input logic [7:0] x, input int mv, input int lv);
    int s, a, k, mul, num, den, q;
    s = int'(x) - 128;
    a = (40 - mv) + (20 - lv);
    k = a / 3;
    case (a % 3)
      0:       mul = 256;
      1:       mul = 203;
      default: mul = 161;
    endcase
    num = s * mul;
    den = 1 << (8 + k);
    q   = num / den;
    if ((num % den) != 0 && num < 0) q = q - 1;
    return 8'(q + 128);
  endfunction

  task automatic model_reset();
    m_master = 40; m_left = 20; m_right = 20;
    m_bass = 6; m_treble = 6; m_mix = 1;
  endtask

  task automatic add_fixed(input logic [7:0] l, input logic [7:0] r,
                           input logic [7:0] el, input logic [7:0] er);
    stim_l.push_back(l); stim_r.push_back(r);
    want_l.push_back(el); want_r.push_back(er);
  endtask

  task automatic add_model(input logic [7:0] l, input logic [7:0] r);
    add_fixed(l, r, model_sample(l, m_master, m_left), model_sample(r, m_master, m_right));
  endtask

  // Drives the queued samples back-to-back and scores the outputs as they emerge
  task automatic run_audio(input string name);
    int n;
    exp_t e;
    logic [7:0] last_l, last_r;
    n = stim_l.size();
    last_l = 8'h80; last_r = 8'h80;
    for (int c = 0; c < n + 4; c++) begin
      @(negedge clk32);
      if (audio_out_strobe) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL %s: unexpected output strobe at cycle %0d", name, c);
        end else begin
          e = sb.pop_front();
          last_l = e.l; last_r = e.r;
          if (e.due != c || audio_out_l !== e.l || audio_out_r !== e.r) begin
            n_fail++;
            $display("FAIL %s: cycle %0d l=%h r=%h, required cycle %0d l=%h r=%h",
                     name, c, audio_out_l, audio_out_r, e.due, e.l, e.r);
          end
        end
      end
      if (c < n) begin
        audio_in_strobe = 1'b1;
        audio_in_l = stim_l[c];
        audio_in_r = stim_r[c];
        e.due = c + 2; e.l = want_l[c]; e.r = want_r[c];
        sb.push_back(e);
      end else begin
        audio_in_strobe = 1'b0;
        audio_in_l = 8'h00;
        audio_in_r = 8'h00;
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d samples never produced, required 0", name, sb.size());
    end
    n_checks++;
    if (audio_out_l !== last_l || audio_out_r !== last_r) begin
      n_fail++;
      $display("FAIL %s_hold: l=%h r=%h, required l=%h r=%h",
               name, audio_out_l, audio_out_r, last_l, last_r);
    end
    sb.delete(); stim_l.delete(); stim_r.delete(); want_l.delete(); want_r.delete();
  endtask

  // Sends n bits MSB-first with masked slots interleaved, then checks decode results
  task automatic send_frame(input string name, input logic [15:0] bits, input int n,
                            input bit last_with_done);
    logic err_exp;
    int v;
    err_exp = (n != 11);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk32);
      mw_bclk = 1'b1; mw_en = 1'b1; mw_data = bits[i];
      if (i == 0 && last_with_done) mw_done = 1'b1;
      @(negedge clk32);
      mw_bclk = 1'b0; mw_en = 1'b0; mw_done = 1'b0;
      if (i % 3 == 1) begin
        @(negedge clk32);
        mw_bclk = 1'b1; mw_en = 1'b0; mw_data = ~bits[i];
        @(negedge clk32);
        mw_bclk = 1'b0;
      end
    end
    if (!last_with_done) begin
      @(negedge clk32);
      mw_done = 1'b1;
      @(negedge clk32);
      mw_done = 1'b0;
    end
    if (n == 11 && bits[10:9] == 2'b10) begin
      case (bits[8:6])
        3'b011: begin v = int'(bits[5:0]); m_master = (v > 40) ? 40 : v; end
        3'b101: begin v = int'(bits[4:0]); m_left   = (v > 20) ? 20 : v; end
        3'b100: begin v = int'(bits[4:0]); m_right  = (v > 20) ? 20 : v; end
        3'b000: m_mix = int'(bits[1:0]);
`ifdef LMC_TONE_EN
        3'b001: begin v = int'(bits[3:0]); m_bass   = (v > 12) ? 12 : v; end
        3'b010: begin v = int'(bits[3:0]); m_treble = (v > 12) ? 12 : v; end
`endif
        default: ;
      endcase
    end
    n_checks++;
    if (frame_err !== err_exp) begin
      n_fail++;
      $display("FAIL %s_err: frame_err=%b, required %b", name, frame_err, err_exp);
    end
    n_checks++;
    if ({master_vol, left_vol, right_vol, bass, treble, mix} !==
        {6'(m_master), 5'(m_left), 5'(m_right), 4'(m_bass), 4'(m_treble), 2'(m_mix)}) begin
      n_fail++;
      $display("FAIL %s_regs: m=%0d l=%0d r=%0d b=%0d t=%0d x=%0d, required m=%0d l=%0d r=%0d b=%0d t=%0d x=%0d",
               name, master_vol, left_vol, right_vol, bass, treble, mix,
               m_master, m_left, m_right, m_bass, m_treble, m_mix);
    end
    @(negedge clk32);
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_err_pulse: frame_err=%b one cycle later, required 0", name, frame_err);
    end
  endtask

  task automatic test_reset();
    resb = 1'b0;
    repeat (3) @(negedge clk32);
    model_reset();
    n_checks++;
    if ({master_vol, left_vol, right_vol, bass, treble, mix} !== {6'd40, 5'd20, 5'd20, 4'd6, 4'd6, 2'd1}) begin
      n_fail++;
      $display("FAIL reset_regs: m=%0d l=%0d r=%0d b=%0d t=%0d x=%0d, required 40 20 20 6 6 1",
               master_vol, left_vol, right_vol, bass, treble, mix);
    end
    n_checks++;
    if ({audio_out_strobe, frame_err, audio_out_l, audio_out_r} !== {1'b0, 1'b0, 8'h80, 8'h80}) begin
      n_fail++;
      $display("FAIL reset_audio: stb=%b err=%b l=%h r=%h, required 0 0 80 80",
               audio_out_strobe, frame_err, audio_out_l, audio_out_r);
    end
    resb = 1'b1;
    @(negedge clk32);
  endtask

  task automatic test_master37();
    send_frame("master37", 16'b10_011_100101, 11, 1'b0);
    add_fixed(8'hFF, 8'h00, 8'hBF, 8'h40);
    add_fixed(8'h00, 8'hFF, 8'h40, 8'hBF);
    run_audio("master37_audio");
  endtask

  task automatic test_left_atten1();
    send_frame("master39", 16'b10_011_100111, 11, 1'b0);
    send_frame("left20", 16'b10_101_010100, 11, 1'b0);
    add_fixed(8'hFF, 8'hFF, 8'hE4, 8'hE4);
    run_audio("atten1_audio");
  endtask

  task automatic test_clamp();
    send_frame("left5", 16'b10_101_000101, 11, 1'b0);
    send_frame("master_clamp", 16'b10_011_111111, 11, 1'b0);
    send_frame("left_clamp", 16'b10_101_111111, 11, 1'b0);
    send_frame("right10", 16'b10_100_001010, 11, 1'b0);
    send_frame("mix3", 16'b10_000_000011, 11, 1'b0);
    add_model(8'hFF, 8'hFF);
    add_model(8'h00, 8'h00);
    run_audio("clamp_audio");
  endtask

  task automatic test_frame_err();
    send_frame("short9", 16'b011_000011, 9, 1'b0);
    send_frame("long12", 16'b0_10_011_000001, 12, 1'b0);
    send_frame("bad_addr", 16'b01_011_000001, 11, 1'b0);
    send_frame("cmd111", 16'b10_111_000001, 11, 1'b0);
  endtask

  task automatic test_atten60();
    send_frame("master0", 16'b10_011_000000, 11, 1'b0);
    send_frame("left0", 16'b10_101_000000, 11, 1'b0);
    send_frame("right0", 16'b10_100_000000, 11, 1'b0);
    add_fixed(8'hFF, 8'h00, 8'h80, 8'h7F);
    add_fixed(8'h00, 8'hFF, 8'h7F, 8'h80);
    run_audio("atten60_audio");
  endtask

  task automatic test_done_with_last_bit();
    send_frame("mix_last_bit", 16'b10_000_000010, 11, 1'b1);
    send_frame("master_last_bit", 16'b10_011_011001, 11, 1'b1);
  endtask

  task automatic test_tone();
    send_frame("bass9", 16'b10_001_001001, 11, 1'b0);
    send_frame("treble_clamp", 16'b10_010_001111, 11, 1'b0);
    send_frame("bass_clamp", 16'b10_001_001111, 11, 1'b0);
    send_frame("cmd110", 16'b10_110_000101, 11, 1'b0);
  endtask

  task automatic test_back_to_back();
    send_frame("master33", 16'b10_011_100001, 11, 1'b0);
    send_frame("left17", 16'b10_101_010001, 11, 1'b0);
    send_frame("right11", 16'b10_100_001011, 11, 1'b0);
    add_model(8'h00, 8'hFF);
    add_model(8'h80, 8'h80);
    for (int i = 0; i < 14; i++)
      add_model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    run_audio("b2b_audio");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk32);
      mw_bclk = 1'b1; mw_en = 1'b1; mw_data = i[0];
      @(negedge clk32);
      mw_bclk = 1'b0; mw_en = 1'b0;
    end
    audio_in_strobe = 1'b1; audio_in_l = 8'hFF; audio_in_r = 8'h00;
    @(negedge clk32);
    audio_in_strobe = 1'b0;
    resb = 1'b0;
    #1;
    n_checks++;
    if ({master_vol, left_vol, right_vol, mix, audio_out_strobe, audio_out_l, audio_out_r} !==
        {6'd40, 5'd20, 5'd20, 2'd1, 1'b0, 8'h80, 8'h80}) begin
      n_fail++;
      $display("FAIL reset_mid_regs: m=%0d l=%0d r=%0d x=%0d stb=%b out=%h/%h, required 40 20 20 1 0 80/80",
               master_vol, left_vol, right_vol, mix, audio_out_strobe, audio_out_l, audio_out_r);
    end
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk32);
      if (c == 1) resb = 1'b1;
      n_checks++;
      if (audio_out_strobe !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_drop: strobe=%b at cycle %0d, required 0", audio_out_strobe, c);
      end
    end
    send_frame("after_reset_master30", 16'b10_011_011110, 11, 1'b0);
    add_model(8'hFF, 8'h00);
    add_model(8'h3C, 8'hC4);
    run_audio("after_reset_audio");
  endtask

  initial begin
    resb = 1'b0;
    mw_bclk = 1'b0; mw_en = 1'b0; mw_data = 1'b0; mw_done = 1'b0;
    audio_in_strobe = 1'b0; audio_in_l = 8'h00; audio_in_r = 8'h00;
    model_reset();
    test_reset();
    test_master37();
    test_left_atten1();
    test_clamp();
    test_frame_err();
    test_atten60();
    test_done_with_last_bit();
    test_tone();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
